// File: rtl/tournament_select_if.sv
// Chromosome-pair input channel (with its fitness results) and parent-pair output channel.
interface tournament_select_if #(
  parameter int CHROM_W = 8,
  parameter int FIT_W   = 27
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [CHROM_W-1:0] chrom1;
  logic signed [CHROM_W-1:0] chrom2;
  logic signed [FIT_W-1:0]   fitness1;
  logic signed [FIT_W-1:0]   fitness2;
  logic                      parent_valid;
  logic                      parent_ready;
  logic signed [CHROM_W-1:0] parent_a;
  logic signed [CHROM_W-1:0] parent_b;

  modport master (
    output in_valid, chrom1, chrom2, fitness1, fitness2, parent_ready,
    input  in_ready, parent_valid, parent_a, parent_b
  );

  modport slave (
    input  in_valid, chrom1, chrom2, fitness1, fitness2, parent_ready,
    output in_ready, parent_valid, parent_a, parent_b
  );
endinterface

// File: rtl/tournament_select.sv
// 2-way tournament on fitness_function results; winner pair visible FF_LATENCY+1 cycles after the second accept.
// in_ready is credit-based on registered state, so the parent FIFO cannot overflow while parent_ready is low.
module tournament_select #(
  parameter int CHROM_W    = 8,
  parameter int FIT_W      = 27,
  parameter int FF_LATENCY = 3,
  parameter int PAIR_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tournament_select_if.slave        bus,
  input  logic                      gen_start,
  output logic signed [CHROM_W-1:0] best_chrom,
  output logic signed [FIT_W-1:0]   best_fitness,
  output logic                      best_valid
);
  localparam int PTR_W  = $clog2(PAIR_DEPTH);
  localparam int CNT_W  = $clog2(PAIR_DEPTH + 1);
  localparam int CRED_W = $clog2(2 * PAIR_DEPTH + FF_LATENCY + 2);

  typedef enum logic {EMPTY, HALF} state_t;

  state_t                    state_q, state_d;
  logic                      accept, tail_vld, push, pop, hold_load;
  logic                      vld_q [FF_LATENCY];
  logic signed [CHROM_W-1:0] c1_q [FF_LATENCY];
  logic signed [CHROM_W-1:0] c2_q [FF_LATENCY];
  logic signed [CHROM_W-1:0] win_chrom, hold_a;
  logic signed [FIT_W-1:0]   win_fit;
  logic signed [CHROM_W-1:0] mem_a [PAIR_DEPTH];
  logic signed [CHROM_W-1:0] mem_b [PAIR_DEPTH];
  logic signed [CHROM_W-1:0] last_a, last_b;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [CRED_W-1:0]         inflight, credit_used;

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FF_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        c1_q[i]  <= '0;
        c2_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      c1_q[0]  <= bus.chrom1;
      c2_q[0]  <= bus.chrom2;
      for (int i = 1; i < FF_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        c1_q[i]  <= c1_q[i-1];
        c2_q[i]  <= c2_q[i-1];
      end
    end
  end

  // Fitness arrives exactly as the chromosomes reach the tail; ties favour chrom1.
  assign tail_vld  = vld_q[FF_LATENCY-1];
  assign win_chrom = ($signed(bus.fitness1) >= $signed(bus.fitness2)) ? c1_q[FF_LATENCY-1] : c2_q[FF_LATENCY-1];
  assign win_fit   = ($signed(bus.fitness1) >= $signed(bus.fitness2)) ? bus.fitness1 : bus.fitness2;

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    hold_load = 1'b0;
    if (gen_start) begin
      state_d = EMPTY;
      if (tail_vld) begin
        hold_load = 1'b1;
        state_d   = HALF;
      end
    end else if (tail_vld) begin
      case (state_q)
        EMPTY: begin
          hold_load = 1'b1;
          state_d   = HALF;
        end
        HALF: begin
          push    = 1'b1;
          state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hold_a  <= '0;
    end else begin
      state_q <= state_d;
      if (hold_load) hold_a <= win_chrom;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_chrom   <= '0;
      best_fitness <= '0;
      best_valid   <= 1'b0;
    end else if (tail_vld && (gen_start || !best_valid || win_fit > best_fitness)) begin
      best_chrom   <= win_chrom;
      best_fitness <= win_fit;
      best_valid   <= 1'b1;
    end else if (gen_start) begin
      best_valid <= 1'b0;
    end
  end

  assign bus.parent_valid = (fifo_cnt != '0);
  assign pop              = bus.parent_valid & bus.parent_ready;
  assign bus.parent_a     = bus.parent_valid ? mem_a[rd_ptr] : last_a;
  assign bus.parent_b     = bus.parent_valid ? mem_b[rd_ptr] : last_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAIR_DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      last_a   <= '0;
      last_b   <= '0;
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= hold_a;
        mem_b[wr_ptr] <= win_chrom;
        wr_ptr        <= (wr_ptr == PTR_W'(PAIR_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        last_a <= mem_a[rd_ptr];
        last_b <= mem_b[rd_ptr];
        rd_ptr <= (rd_ptr == PTR_W'(PAIR_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Each accepted pair costs one half-slot until it leaves the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < FF_LATENCY; i++) inflight = inflight + CRED_W'(vld_q[i]);
    credit_used = (CRED_W'(fifo_cnt) << 1) + inflight + CRED_W'(state_q == HALF);
  end

  assign bus.in_ready = (credit_used < CRED_W'(2 * PAIR_DEPTH));
endmodule

// File: doc/tournament_select.md
Name: tournament_select

Overview:
- Downstream of fitness_function; consumes the two fitness values it produces and runs a 2-way tournament per chromosome pair.
- Chromosome pairs are accepted on the same cycle they are presented to fitness_function.
- The block delays the chromosomes internally so they line up with fitness1/fitness2, then keeps the winner of each pair.
- Winners are grouped into parent pairs and buffered in a small FIFO for the crossover stage; the best-so-far individual of the generation is also tracked.

Parameters:
- CHROM_W, 8, chromosome width (signed).
- FIT_W, 27, fitness width (signed).
- FF_LATENCY, 3, cycles from chrom1/chrom2 at fitness_function to the matching fitness1/fitness2; must be ≥1.
- PAIR_DEPTH, 4, parent-pair FIFO depth; must be ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  chrom1/chrom2 valid this cycle (also drives fitness_function).
- in_ready  out  1  block can accept a pair; upstream must not assert in_valid while in_ready=0.
- chrom1  in  CHROM_W  signed chromosome A.
- chrom2  in  CHROM_W  signed chromosome B.
- fitness1  in  FIT_W  signed fitness of chrom1, valid FF_LATENCY cycles after acceptance.
- fitness2  in  FIT_W  signed fitness of chrom2, same timing.
- gen_start  in  1  one-cycle pulse; clears the best-so-far record and any half-formed pair.
- parent_valid  out  1  FIFO head holds a parent pair.
- parent_ready  in  1  consumer takes the head pair when parent_valid=1.
- parent_a  out  CHROM_W  first winner of the head pair.
- parent_b  out  CHROM_W  second winner of the head pair.
- best_chrom  out  CHROM_W  best winner since the last reset or gen_start.
- best_fitness  out  FIT_W  its fitness.
- best_valid  out  1  best_chrom/best_fitness are meaningful.

Behaviour:
- Reset (async, rst_n=0): all delay-line valid bits, hold state, FIFO pointers and count, best_valid → 0. All data outputs → 0. parent_valid=0; in_ready=1 once reset is released.
- Accept: in_valid & in_ready. This shifts {1, chrom1, chrom2} into an FF_LATENCY-deep delay line; otherwise a 0 valid bit is shifted in.
- Compare: at the delay-line tail (cycle t+FF_LATENCY for an acceptance at t), fitness1/fitness2 are sampled.
  - Winner = chrom1 if signed fitness1 ≥ fitness2; otherwise chrom2. Ties go to chrom1.
  - All compares are full-width signed; no truncation.
- Pairing FSM, two states:
  - EMPTY: a tail winner is registered into hold_a → state HALF.
  - HALF: a tail winner pushes {hold_a, winner} into the FIFO → state EMPTY.
  - The push is visible as parent_valid at t+FF_LATENCY+1.
- FIFO:
  - PAIR_DEPTH entries, first-word fall-through; parent_a/parent_b show the head entry.
  - Pop on parent_valid & parent_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - parent_a/b hold their last value when the FIFO is empty.
- Credit / in_ready:
  - in_ready = (2·fifo_count + inflight + (state==HALF)) < 2·PAIR_DEPTH, using registered values only.
  - inflight = number of valid bits in the delay line.
  - A pop's freed credit takes effect the following cycle.
  - The FIFO therefore never overflows, and fitness_function never needs to stall.
- Best tracker: on each tail winner, update best_chrom/best_fitness and set best_valid=1 if best_valid=0 or winner fitness > best_fitness (strictly greater, so the earlier one wins ties).
- gen_start:
  - In that cycle, best_valid and the hold state are cleared; a half pair is discarded.
  - If a tail winner arrives in the same cycle, it seeds the new best (best_valid=1) and goes into hold_a (state HALF).
  - In-flight delay-line entries and FIFO contents are unaffected.
- Reset mid-operation discards in-flight entries, the half pair and the FIFO contents immediately.

Test Plan:
1. Reset, then one pair chrom1=5, chrom2=-3 with fitness1=100, fitness2=40 at t+3. Required: best_chrom=5, best_fitness=100, best_valid=1 at t+4; parent_valid stays 0 (state HALF).
2. Two back-to-back pairs: (5,-3; 100,40) and (7,9; -20,-10). Required: at t+5, parent_valid=1, parent_a=5, parent_b=9; best unchanged at 5/100.
3. Tie: fitness1=fitness2=-50 with chrom1=12, chrom2=13. Required: winner is 12. A later winner with fitness -50 does not replace the best.
4. Back-pressure: parent_ready=0 and in_valid held high. Required: in_ready drops after exactly 8 acceptances (PAIR_DEPTH=4); 4 pairs are buffered with no loss. After one pop, in_ready rises the next cycle and two more pairs are accepted.
5. gen_start on the same cycle as a tail winner with fitness -200, when the previous best was 100. Required: next cycle best_fitness=-200, best_valid=1, and any earlier half pair is dropped.
6. rst_n low for 1 cycle with 3 pairs in flight and 2 in the FIFO. Required: parent_valid=0, best_valid=0 and in_ready=1 immediately, and no stale pairs appear afterwards.
